alusrcb_stage: RTL and testbench

ALUSRCB_STAGE -- requirements
Module: alusrcb_stage

---
 rtl/alusrcb_stage_if.sv | 33 +++
 rtl/alusrcb_stage.sv | 101 ++++++++++
 tb/tb_alusrcb_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alusrcb_stage_if.sv
// Operand-B stage bundle: decode-side inputs, hazard-unit forwarding controls
// and the execute-side operand, store data and illegal-select status.
interface alusrcb_stage_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             stall_e;
  logic             flush_e;
  logic             valid_d;
  logic [2:0]       alu_src_b_d;
  logic [WIDTH-1:0] imm_ext_d;
  logic [WIDTH-1:0] rd_data2_d;
  logic [1:0]       forward_b_e;
  logic [WIDTH-1:0] alu_result_m;
  logic [WIDTH-1:0] result_w;
  logic             valid_e;
  logic [WIDTH-1:0] src_b_e;
  logic [WIDTH-1:0] write_data_e;
  logic             illegal_sel_e;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output stall_e, flush_e, valid_d, alu_src_b_d, imm_ext_d, rd_data2_d,
           forward_b_e, alu_result_m, result_w,
    input  valid_e, src_b_e, write_data_e, illegal_sel_e, illegal_cnt
  );

  modport slave (
    input  stall_e, flush_e, valid_d, alu_src_b_d, imm_ext_d, rd_data2_d,
           forward_b_e, alu_result_m, result_w,
    output valid_e, src_b_e, write_data_e, illegal_sel_e, illegal_cnt
  );
endinterface

// File: rtl/alusrcb_stage.sv
// D/E pipeline register for ALU operand B with rs2 forwarding, operand-B
// select mux and a saturating counter of executed undefined select encodings.
module alusrcb_stage #(
  parameter int WIDTH   = 32,
  parameter int CONST_A = 4,
  parameter int CONST_B = 12,
  parameter int CNT_W   = 8
) (
  input  logic           clk,
  input  logic           reset,
  alusrcb_stage_if.slave bus
);

  localparam logic [2:0]       SEL_RS2  = 3'b000;
  localparam logic [2:0]       SEL_IMM  = 3'b010;
  localparam logic [2:0]       SEL_CA   = 3'b100;
  localparam logic [2:0]       SEL_CB   = 3'b110;
  localparam logic [WIDTH-1:0] CONST_AW = WIDTH'(CONST_A);
  localparam logic [WIDTH-1:0] CONST_BW = WIDTH'(CONST_B);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             valid_q, valid_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] rd2_q, rd2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] rs2_fwd;
  logic [WIDTH-1:0] src_b;
  logic             illegal_sel;

  // Flush wins over stall: a stalled-and-flushed slot still becomes a bubble.
  always_comb begin
    valid_d = valid_q;
    sel_d   = sel_q;
    imm_d   = imm_q;
    rd2_d   = rd2_q;
    if (bus.flush_e) begin
      valid_d = 1'b0;
      sel_d   = SEL_RS2;
      imm_d   = '0;
      rd2_d   = '0;
    end else if (!bus.stall_e) begin
      valid_d = bus.valid_d;
      sel_d   = bus.alu_src_b_d;
      imm_d   = bus.imm_ext_d;
      rd2_d   = bus.rd_data2_d;
    end
  end

  always_comb begin
    unique case (bus.forward_b_e)
      2'b01:   rs2_fwd = bus.result_w;
      2'b10:   rs2_fwd = bus.alu_result_m;
      default: rs2_fwd = rd2_q;
    endcase
  end

  always_comb begin
    unique case (sel_q)
      SEL_IMM: src_b = imm_q;
      SEL_CA:  src_b = CONST_AW;
      SEL_CB:  src_b = CONST_BW;
      default: src_b = rs2_fwd;
    endcase
  end

  // The four defined encodings are exactly the even ones.
  assign illegal_sel = valid_q & sel_q[0];

  // Counted on the edge the instruction leaves E, so a stall counts it once.
  always_comb begin
    cnt_d = cnt_q;
    if (illegal_sel && !bus.stall_e && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      sel_q   <= SEL_RS2;
      imm_q   <= '0;
      rd2_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sel_q   <= sel_d;
      imm_q   <= imm_d;
      rd2_q   <= rd2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.valid_e       = valid_q;
  assign bus.src_b_e       = src_b;
  assign bus.write_data_e  = rs2_fwd;
  assign bus.illegal_sel_e = illegal_sel;
  assign bus.illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_alusrcb_stage.sv
// Directed bench for alusrcb_stage: a vector table for single-edge behaviour
// plus sequences for stall counting, stall+flush, saturation and reset.
module tb_alusrcb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, valid;
  logic [2:0]  sel;
  logic [31:0] imm, rd2, alu_m, res_w;
  logic [1:0]  fwd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alusrcb_stage_if #(.WIDTH(32), .CNT_W(8)) bus0 ();
  alusrcb_stage_if #(.WIDTH(32), .CNT_W(2)) bus1 ();

  assign bus0.stall_e = stall;      assign bus1.stall_e = stall;
  assign bus0.flush_e = flush;      assign bus1.flush_e = flush;
  assign bus0.valid_d = valid;      assign bus1.valid_d = valid;
  assign bus0.alu_src_b_d = sel;    assign bus1.alu_src_b_d = sel;
  assign bus0.imm_ext_d = imm;      assign bus1.imm_ext_d = imm;
  assign bus0.rd_data2_d = rd2;     assign bus1.rd_data2_d = rd2;
  assign bus0.forward_b_e = fwd;    assign bus1.forward_b_e = fwd;
  assign bus0.alu_result_m = alu_m; assign bus1.alu_result_m = alu_m;
  assign bus0.result_w = res_w;     assign bus1.result_w = res_w;

  alusrcb_stage #(.WIDTH(32), .CONST_A(4), .CONST_B(12), .CNT_W(8))
    u_dut (.clk(clk), .reset(reset), .bus(bus0));
  alusrcb_stage #(.WIDTH(32), .CONST_A(4), .CONST_B(12), .CNT_W(2))
    u_sat (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic        stall, flush, valid;
    logic [2:0]  sel;
    logic [31:0] imm, rd2;
    logic [1:0]  fwd;
    logic [31:0] alu_m, res_w;
    logic        e_valid;
    logic [31:0] e_src_b, e_wd;
    logic        e_ill;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic st, logic fl, logic v, logic [2:0] s,
                              logic [31:0] i, logic [31:0] r, logic [1:0] f,
                              logic [31:0] am, logic [31:0] rw, logic ev,
                              logic [31:0] es, logic [31:0] ew, logic ei,
                              logic [31:0] ec);
    vec_t t;
    t.stall = st; t.flush = fl; t.valid = v; t.sel = s; t.imm = i; t.rd2 = r;
    t.fwd = f; t.alu_m = am; t.res_w = rw; t.e_valid = ev; t.e_src_b = es;
    t.e_wd = ew; t.e_ill = ei; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic v,
                       input logic [2:0] s, input logic [31:0] i,
                       input logic [31:0] r, input logic [1:0] f,
                       input logic [31:0] am, input logic [31:0] rw);
    @(negedge clk);
    stall = st; flush = fl; valid = v; sel = s; imm = i; rd2 = r;
    fwd = f; alu_m = am; res_w = rw;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string nm, input logic ev, input logic [31:0] es,
                           input logic [31:0] ew, input logic ei, input logic [31:0] ec);
    chk({nm, ".valid_e"}, {31'd0, bus0.valid_e}, {31'd0, ev});
    chk({nm, ".src_b_e"}, bus0.src_b_e, es);
    chk({nm, ".write_data_e"}, bus0.write_data_e, ew);
    chk({nm, ".illegal_sel_e"}, {31'd0, bus0.illegal_sel_e}, {31'd0, ei});
    chk({nm, ".illegal_cnt"}, {24'd0, bus0.illegal_cnt}, ec);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 0; flush = 0; valid = 0; sel = 3'b000;
    imm = 0; rd2 = 0; fwd = 2'b00; alu_m = 0; res_w = 0;

    //            st fl v  sel     imm         rd2         fwd    alu_m       res_w   | ev src_b        wd          ill cnt
    vecs[0]  = mk(0, 0, 1, 3'b010, 32'h0FF0,   32'h1234,   2'b00, 32'h0,      32'h0,    1, 32'h0FF0,    32'h1234,   0, 0);
    vecs[1]  = mk(1, 0, 1, 3'b100, 32'h0,      32'h9999,   2'b00, 32'h0,      32'h0,    1, 32'h0FF0,    32'h1234,   0, 0);
    vecs[2]  = mk(0, 0, 1, 3'b000, 32'h0,      32'h5,      2'b10, 32'hAA,     32'h0,    1, 32'hAA,      32'hAA,     0, 0);
    vecs[3]  = mk(1, 0, 0, 3'b111, 32'h0,      32'h0,      2'b01, 32'hAA,     32'h55,   1, 32'h55,      32'h55,     0, 0);
    vecs[4]  = mk(1, 0, 0, 3'b111, 32'h0,      32'h0,      2'b11, 32'hAA,     32'h55,   1, 32'h5,       32'h5,      0, 0);
    vecs[5]  = mk(0, 0, 1, 3'b100, 32'h0,      32'h7,      2'b00, 32'h0,      32'h0,    1, 32'd4,       32'h7,      0, 0);
    vecs[6]  = mk(0, 0, 1, 3'b110, 32'h0,      32'h8,      2'b00, 32'h0,      32'h0,    1, 32'd12,      32'h8,      0, 0);
    vecs[7]  = mk(0, 0, 1, 3'b111, 32'h0,      32'h77,     2'b00, 32'h0,      32'h0,    1, 32'h77,      32'h77,     1, 0);
    vecs[8]  = mk(0, 0, 1, 3'b010, 32'h33,     32'h1,      2'b00, 32'h0,      32'h0,    1, 32'h33,      32'h1,      0, 1);
    vecs[9]  = mk(0, 0, 0, 3'b101, 32'h0,      32'h2,      2'b00, 32'h0,      32'h0,    0, 32'h2,       32'h2,      0, 1);
    vecs[10] = mk(0, 1, 1, 3'b010, 32'h9,      32'h3,      2'b00, 32'h0,      32'h0,    0, 32'h0,       32'h0,      0, 1);
    vecs[11] = mk(0, 0, 1, 3'b001, 32'h0,      32'hC3,     2'b10, 32'hDEAD,   32'h0,    1, 32'hDEAD,    32'hDEAD,   1, 1);
    vecs[12] = mk(0, 1, 1, 3'b011, 32'h0,      32'h4,      2'b00, 32'h0,      32'h0,    0, 32'h0,       32'h0,      0, 2);

    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 13; k++) begin
      drive(vecs[k].stall, vecs[k].flush, vecs[k].valid, vecs[k].sel, vecs[k].imm,
            vecs[k].rd2, vecs[k].fwd, vecs[k].alu_m, vecs[k].res_w);
      check_all($sformatf("vec%0d", k), vecs[k].e_valid, vecs[k].e_src_b,
                vecs[k].e_wd, vecs[k].e_ill, vecs[k].e_cnt);
    end

    // Illegal select held by a 3-cycle stall counts once, on release.
    drive(0, 0, 1, 3'b011, 0, 32'h21, 2'b00, 0, 0);
    check_all("stall_load", 1, 32'h21, 32'h21, 1, 2);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 3'b000, 0, 32'hFF, 2'b00, 0, 0);
      check_all($sformatf("stall_hold%0d", k), 1, 32'h21, 32'h21, 1, 2);
    end
    drive(0, 0, 1, 3'b000, 0, 32'h42, 2'b00, 0, 0);
    check_all("stall_release", 1, 32'h42, 32'h42, 0, 3);

    // Stall and flush on the same edge: bubble, and no count since stalled.
    drive(0, 0, 1, 3'b101, 32'h6, 32'h66, 2'b00, 0, 0);
    check_all("sf_load", 1, 32'h66, 32'h66, 1, 3);
    drive(1, 1, 1, 3'b010, 32'h7, 32'h77, 2'b00, 0, 0);
    check_all("stall_flush", 0, 0, 0, 0, 3);
    drive(0, 0, 1, 3'b000, 0, 32'h1, 2'b00, 0, 0);
    check_all("after_sf", 1, 32'h1, 32'h1, 0, 3);

    // Saturation of the 2-bit counter over consecutive illegal instructions.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 3'b111, 0, 32'h10 + k, 2'b00, 0, 0);
      chk($sformatf("sat_edge%0d", k), {30'd0, bus1.illegal_cnt}, (k > 3) ? 32'd3 : k);
      chk($sformatf("sat_ill%0d", k), {31'd0, bus1.illegal_sel_e}, 32'd1);
    end
    drive(1, 0, 1, 3'b000, 0, 0, 2'b00, 0, 0);
    chk("sat_hold", {30'd0, bus1.illegal_cnt}, 32'd3);
    chk("wide_cnt", {24'd0, bus0.illegal_cnt}, 32'd4);

    // Reset during a stall with the counter saturated.
    @(negedge clk);
    reset = 1'b1; stall = 1'b1; flush = 1'b0; fwd = 2'b00;
    @(posedge clk); #1;
    chk("rst_stall.cnt", {30'd0, bus1.illegal_cnt}, 32'd0);
    chk("rst_stall.valid", {31'd0, bus1.valid_e}, 32'd0);
    chk("rst_stall.src_b", bus1.src_b_e, 32'd0);
    chk("rst_stall.wd", bus1.write_data_e, 32'd0);
    chk("rst_stall.ill", {31'd0, bus1.illegal_sel_e}, 32'd0);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
